// File: rtl/bitserial_alu.sv
// bitserial_alu
//   Datapath ALU between the lab control FSM and the register file.
//   Operands are latched on start and pushed through BITS_PER_CYCLE chained
//   one-bit slices per clock, LSB first, with the carry held in a flop
//   between clocks. An operation takes N = WIDTH/BITS_PER_CYCLE clocks.
//
//   Optional feature macro: BITSERIAL_ALU_ABORT_EN (adds the abort input).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while busy=0
//   a, b       operands (WIDTH bits)
//   b_invert   invert b before the slices (AND/OR/ADD)
//   carry_in   carry into bit 0 (ADD)
//   operation  00 AND, 01 OR, 10 ADD, 11 SLT (signed a < b)
//   abort      (BITSERIAL_ALU_ABORT_EN only) drop the running operation
//   busy       operation in progress
//   done       one-cycle pulse, result/flags just updated
//   result     registered result
//   carry_out  carry out of MSB (ADD/SLT), else 0
//   overflow   signed overflow (ADD/SLT), else 0
//   zero       result == 0
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start; result/flags hold last completed op
//   RUN   | one slice processed per clock, slice counter 0..N-1
module bitserial_alu #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_invert,
  input  logic             carry_in,
  input  logic [1:0]       operation,
`ifdef BITSERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]          a_sh, b_sh;
  logic                      carry_q;
  logic [1:0]                op_q;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_CYCLE-1:0] slice_bits;
  logic                      c_msb, sum_msb, c_out;
  logic [WIDTH-1:0]          full_res, res_final;
  logic                      last, abort_req, is_arith, ovf;

`ifdef BITSERIAL_ALU_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy     = (state_q == RUN);
  assign last     = (cnt == CW'(N - 1));
  assign is_arith = op_q[1];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (abort_req || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- slice chain ----------------
  // c_msb/sum_msb are taken from the top slice of the chain; they only
  // matter on the final clock, when that slice is bit WIDTH-1.
  always_comb begin
    logic c, s;
    c          = carry_q;
    s          = 1'b0;
    slice_bits = '0;
    c_msb      = 1'b0;
    sum_msb    = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      s = a_sh[i] ^ b_sh[i] ^ c;
      case (op_q)
        OP_AND:  slice_bits[i] = a_sh[i] & b_sh[i];
        OP_OR:   slice_bits[i] = a_sh[i] | b_sh[i];
        default: slice_bits[i] = s;
      endcase
      if (i == BITS_PER_CYCLE - 1) begin
        c_msb   = c;
        sum_msb = s;
      end
      c = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
    end
    c_out = c;
  end

  // Partial results enter at the top and shift down; after the last slice
  // the accumulator plus the current slice form the whole word.
  generate
    if (N > 1) begin : g_acc
      logic [WIDTH-BITS_PER_CYCLE-1:0] acc;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          acc <= '0;
        else if (state_q == RUN && !abort_req)
          acc <= full_res[WIDTH-1:BITS_PER_CYCLE];
      end
      assign full_res = {slice_bits, acc};
    end else begin : g_noacc
      assign full_res = slice_bits;
    end
  endgenerate

  assign ovf       = c_msb ^ c_out;
  assign res_final = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, sum_msb ^ ovf}
                                      : full_res;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry_q   <= 1'b0;
      op_q      <= OP_AND;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // SLT is a - b regardless of the b_invert/carry_in pins
            a_sh    <= a;
            b_sh    <= (b_invert || operation == OP_SLT) ? ~b : b;
            carry_q <= (operation == OP_SLT) ? 1'b1 : carry_in;
            op_q    <= operation;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (!abort_req) begin
            a_sh    <= a_sh >> BITS_PER_CYCLE;
            b_sh    <= b_sh >> BITS_PER_CYCLE;
            carry_q <= c_out;
            cnt     <= cnt + CW'(1);
            if (last) begin
              result    <= res_final;
              carry_out <= is_arith & c_out;
              overflow  <= is_arith & ovf;
              zero      <= (res_final == '0);
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_alu.sv
module tb_bitserial_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, b_invert, carry_in;
  logic [7:0]  a, b;
  logic [1:0]  operation;
  logic        busy, done, carry_out, overflow, zero;
  logic [7:0]  result;
`ifdef BITSERIAL_ALU_ABORT_EN
  logic        abort;
`endif

  logic        w_start, w_busy, w_done, w_co, w_ov, w_zero;
  logic [15:0] w_a, w_b, w_result;
  logic [1:0]  w_op;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bitserial_alu #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .b_invert(b_invert), .carry_in(carry_in), .operation(operation),
`ifdef BITSERIAL_ALU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  bitserial_alu #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .a(w_a), .b(w_b),
    .b_invert(1'b0), .carry_in(1'b0), .operation(w_op),
`ifdef BITSERIAL_ALU_ABORT_EN
    .abort(1'b0),
`endif
    .busy(w_busy), .done(w_done), .result(w_result), .carry_out(w_co),
    .overflow(w_ov), .zero(w_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic co,
                           input logic ov, input logic z);
    check({tag, "_res"},  result,    r);
    check({tag, "_co"},   carry_out, co);
    check({tag, "_ov"},   overflow,  ov);
    check({tag, "_zero"}, zero,      z);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns at the negedge of the done cycle; lat = edges from start sample to done.
  task automatic run_op(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic ci, output int lat, output int bcyc);
    @(negedge clk);
    operation = op; a = av; b = bv; b_invert = bi; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcyc  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    lat = lat - 1;
  endtask

  task automatic run_w(input logic [1:0] op, input logic [15:0] av, input logic [15:0] bv,
                       output int lat);
    @(negedge clk);
    w_op = op; w_a = av; w_b = bv; w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    lat = 1;
    while (!w_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    lat = lat - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, n, ndone;
    logic [7:0] r_at_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_invert = 1'b0; carry_in = 1'b0;
    operation = 2'b00;
    w_start = 1'b0; w_a = '0; w_b = '0; w_op = 2'b00;
`ifdef BITSERIAL_ALU_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_w_zero", w_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 7F+01: signed overflow
    run_op(2'b10, 8'h7F, 8'h01, 1'b0, 1'b0, lat, bcyc);
    check("add1_lat", lat, 8);
    check("add1_busycyc", bcyc, 8);
    check("add1_done_busy", busy, 1'b0);
    check_out("add1", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("add1_done_pulse", done, 1'b0);

    // SUB via b_invert/carry_in
    run_op(2'b10, 8'h05, 8'h05, 1'b1, 1'b1, lat, bcyc);
    check_out("sub1", 8'h00, 1'b1, 1'b0, 1'b1);
    run_op(2'b10, 8'h00, 8'h01, 1'b1, 1'b1, lat, bcyc);
    check_out("sub2", 8'hFF, 1'b0, 1'b0, 1'b0);

    // SLT (pins b_invert/carry_in left at 0)
    run_op(2'b11, 8'hFE, 8'h03, 1'b0, 1'b0, lat, bcyc);
    check_out("slt1", 8'h01, 1'b1, 1'b0, 1'b0);
    run_op(2'b11, 8'h03, 8'hFE, 1'b0, 1'b0, lat, bcyc);
    check_out("slt2", 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(2'b11, 8'h80, 8'h01, 1'b0, 1'b0, lat, bcyc);
    check_out("slt3", 8'h01, 1'b1, 1'b1, 1'b0);

    // Logic ops; carry_in=1 must not leak into flags
    run_op(2'b00, 8'hF0, 8'h3C, 1'b0, 1'b1, lat, bcyc);
    check_out("and1", 8'h30, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'hF0, 8'h3C, 1'b0, 1'b1, lat, bcyc);
    check_out("or1", 8'hFC, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 8'hF0, 8'h3C, 1'b1, 1'b1, lat, bcyc);
    check_out("orinv", 8'hF3, 1'b0, 1'b0, 1'b0);

    // Operand change during RUN
    @(negedge clk);
    operation = 2'b10; a = 8'h10; b = 8'h20; b_invert = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; b_invert = 1'b1; operation = 2'b00;
    wait_done(n);
    check("latch_done", done, 1'b1);
    check("latch_res", result, 8'h30);

    // start while busy ignored
    @(negedge clk);
    operation = 2'b10; a = 8'h01; b = 8'h01; b_invert = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    operation = 2'b00; a = 8'h00; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    r_at_done = 8'hXX;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        r_at_done = result;
      end
      @(negedge clk);
    end
    check("ign_ndone", ndone, 1);
    check("ign_res", r_at_done, 8'h02);
    check("ign_busy", busy, 1'b0);

    // Back-to-back: start in the done cycle
    run_op(2'b10, 8'h03, 8'h04, 1'b0, 1'b0, lat, bcyc);
    check("b2b_first", result, 8'h07);
    operation = 2'b01; a = 8'h0F; b = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(n);
    check("b2b_lat", n, 8);
    check("b2b_res", result, 8'h3F);

    // Reset mid-RUN
    run_op(2'b10, 8'h7F, 8'h01, 1'b0, 1'b0, lat, bcyc);
    check_out("pre_rst", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check_out("mrst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_nodone", ndone, 0);
    check("mrst_idle", busy, 1'b0);

`ifdef BITSERIAL_ALU_ABORT_EN
    run_op(2'b10, 8'h10, 8'h20, 1'b0, 1'b0, lat, bcyc);
    check("ab_pre", result, 8'h30);
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_res", result, 8'h30);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ab_nodone", ndone, 0);
    // start beats abort in IDLE
    a = 8'h02; b = 8'h03; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("ab_startwins", busy, 1'b1);
    wait_done(n);
    check("ab_sw_res", result, 8'h05);
`endif

    // WIDTH=16, BPC=4
    run_w(2'b10, 16'hFFFF, 16'h0001, lat);
    check("w1_lat", lat, 4);
    check("w1_res", w_result, 16'h0000);
    check("w1_co", w_co, 1'b1);
    check("w1_ov", w_ov, 1'b0);
    check("w1_zero", w_zero, 1'b1);
    run_w(2'b10, 16'h1234, 16'h4321, lat);
    check("w2_res", w_result, 16'h5555);
    check("w2_co", w_co, 1'b0);
    check("w2_zero", w_zero, 1'b0);
    run_w(2'b11, 16'h8000, 16'h0001, lat);
    check("w3_res", w_result, 16'h0001);
    check("w3_ov", w_ov, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bitserial_alu.md
Name: bitserial_alu

Overview:
- Parametrised multi-bit ALU built around a registered one-bit slice that is reused BITS_PER_CYCLE bits at a time, LSB first.
- Supports AND, OR, ADD/SUB (via b_invert/carry_in) and signed set-less-than.
- Uses a start/busy/done handshake and produces registered result and flags.
- Sits between the lab control FSM and the register file as the datapath ALU.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- b_invert  input  1  invert B before slice (ops 00/01/10).
- carry_in  input  1  carry into bit 0 (op 10).
- operation  input  2  00 AND, 01 OR, 10 ADD, 11 SLT.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result/flags just updated.
- result  output  WIDTH  registered result.
- carry_out  output  1  carry out of MSB (ADD/SLT), else 0.
- overflow  output  1  signed overflow (ADD/SLT), else 0.
- zero  output  1  result == 0.

Behaviour:
- Reset is asynchronous and active-low: rst_n low clears FSM to IDLE and sets busy, done, result, carry_out, overflow and zero to 0. zero resets to 0, not 1. Reset applies regardless of clock.
- Define N = WIDTH/BITS_PER_CYCLE.
- FSM states: IDLE and RUN.
- IDLE → RUN on a clock edge with start=1.
  - Latch a, b (after b_invert), carry_in and operation into shadow registers; later input changes have no effect.
  - Set the slice counter to 0 and busy=1.
- RUN, each edge:
  - Process slice k (bits k*BPC..k*BPC+BPC-1) through BPC chained one-bit slices, using the registered carry.
  - Store the partial result into an internal shift/accumulate register.
  - Update the carry flop; k increments.
- RUN → IDLE on the edge processing slice N-1.
  - result, carry_out, overflow and zero update on that same edge.
  - done=1 for exactly that following cycle; busy=0.
- Latency: start sampled at edge 0 gives done high after edge N (N=8 for default). Throughput is one op per N cycles.
- start while busy=1 is ignored. No queueing, no error indication.
- start=1 in the done cycle is accepted (busy=0 then), giving back-to-back ops with no bubble.
- AND/OR: bitwise on a and the (optionally inverted) b. carry_out=0, overflow=0.
- ADD: result = a + b' + carry_in mod 2^WIDTH, where b' is b after optional inversion.
  - carry_out = carry out of MSB.
  - overflow = carry into MSB XOR carry out of MSB.
- SLT: internally forces b_invert=1 and carry_in=1, ignoring the input pins, and computes a - b.
  - result = {WIDTH-1 zeros, sum_msb XOR overflow}.
  - carry_out and overflow report the subtraction.
- zero always reflects the final result register.
- result and flags hold their value between completions; they are unchanged by rejected starts.
- Reset mid-RUN aborts immediately. No done pulse; outputs return to reset values.

Optional Feature:
- Macro BITSERIAL_ALU_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 on an edge while busy=1 returns to IDLE on that edge; busy=0, done stays 0, result/flags keep prior values.
  - abort in IDLE has no effect.
  - If abort and start are both high in IDLE, start wins.
- Undefined: no abort port; an operation always runs N cycles to completion.

Test Plan:
- WIDTH=8, BPC=1, ADD, a=8'h7F, b=8'h01, b_invert=0, carry_in=0, start pulse -> busy=1 for 8 cycles, then done 1 cycle; result=8'h80, carry_out=0, overflow=1, zero=0.
- ADD with b_invert=1, carry_in=1, a=8'h05, b=8'h05 -> result=8'h00, zero=1, carry_out=1, overflow=0. Repeat with a=8'h00, b=8'h01 -> result=8'hFF, carry_out=0.
- SLT a=8'hFE, b=8'h03 (b_invert/carry_in pins 0) -> result=8'h01. Swapped operands -> 8'h00. a=8'h80, b=8'h01 -> 8'h01 despite overflow=1.
- AND a=8'hF0, b=8'h3C -> 8'h30. OR -> 8'hFC. OR with b_invert=1 -> 8'hF3. carry_out=0, overflow=0 in all three.
- Handshake:
  - Change a/b during RUN -> result uses the latched values.
  - start during busy -> ignored, single done.
  - start in the done cycle -> second done exactly 8 cycles later.
- rst_n low 3 cycles into RUN -> all outputs 0 asynchronously, no done. With BITSERIAL_ALU_ABORT_EN: abort at cycle 4 -> busy=0 next cycle, previous result retained, no done. Also run WIDTH=16, BPC=4: done 4 cycles after start, 16'hFFFF+16'h0001 -> 16'h0000, carry_out=1, zero=1.
